// File: rtl/debug_responder.sv
// debug_responder: SoC-side target of the 2-bit debug bus from the JTAG bridge.
// It decodes register reads and writes (CMD, ADDR, DATA, STATUS) and runs debug
// commands: halt, run, step, CPU register access and 32-bit memory access.
// Every accepted transfer completes with a single-cycle dbg_ack.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   dbg_addr/din/dout   bridge register index, write data, read data (valid with ack)
//   dbg_wr_en, dbg_req  bridge direction and level request
//   dbg_ack             one-cycle completion pulse
//   cpu_run/stopped     run request to the CPU and its halted status
//   cpu_step/step_done  single-step pulse and retire pulse
//   reg_*               CPU register index, write data, write strobe, read data
//   mem_*               memory address, data, direction, access level, ack, read data
module debug_responder #(
  parameter bit          RUN_ON_RESET = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 255   // wait cycles before abort, 1..256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dbg_addr,
  input  logic [31:0] dbg_din,
  output logic [31:0] dbg_dout,
  input  logic        dbg_wr_en,
  input  logic        dbg_req,
  output logic        dbg_ack,
  output logic        cpu_run,
  input  logic        cpu_stopped,
  output logic        cpu_step,
  input  logic        cpu_step_done,
  output logic [3:0]  reg_sel,
  output logic [31:0] reg_wdata,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_access,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] AddrCmd    = 2'd0;
  localparam logic [1:0] AddrAdr    = 2'd1;
  localparam logic [1:0] AddrData   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  localparam logic [2:0] CmdHalt = 3'd0;
  localparam logic [2:0] CmdRun  = 3'd1;
  localparam logic [2:0] CmdStep = 3'd2;
  localparam logic [2:0] CmdRreg = 3'd3;
  localparam logic [2:0] CmdWreg = 3'd4;
  localparam logic [2:0] CmdRmem = 3'd5;
  localparam logic [2:0] CmdWmem = 3'd6;

  // The counter reads 0 in the first wait cycle, so this value marks the last
  // cycle of a MEM_TIMEOUT-cycle window.
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StHaltWait, StStepWait, StMemWait, StAck, StWaitLow
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rd_q, rd_d;
  logic        cmd_ack_q, cmd_ack_d;   // current transfer is a CMD write
  logic        err_q, err_d;
  logic        run_q, run_d;
  logic        step_q, step_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_acc_q, mem_acc_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      cmd_ack_q <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= RUN_ON_RESET;
      step_q    <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_acc_q <= 1'b0;
      mem_we_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      cmd_ack_q <= cmd_ack_d;
      err_q     <= err_d;
      run_q     <= run_d;
      step_q    <= step_d;
      reg_we_q  <= reg_we_d;
      mem_acc_q <= mem_acc_d;
      mem_we_q  <= mem_we_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    cmd_ack_d = cmd_ack_q;
    err_d     = err_q;
    run_d     = run_q;
    step_d    = 1'b0;
    reg_we_d  = 1'b0;
    mem_acc_d = mem_acc_q;
    mem_we_d  = mem_we_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          state_d   = StAck;
          cmd_ack_d = 1'b0;
          rd_d      = '0;
          if (!dbg_wr_en) begin
            case (dbg_addr)
              AddrAdr:  rd_d = addr_q;
              AddrData: rd_d = data_q;
              AddrStatus: rd_d = {29'b0, err_q, 1'b0, cpu_stopped};
              default:  rd_d = '0;
            endcase
          end else begin
            case (dbg_addr)
              AddrAdr:  addr_d = dbg_din;
              AddrData: data_d = dbg_din;
              AddrCmd: begin
                cmd_ack_d = 1'b1;
                err_d     = 1'b0;
                case (dbg_din[2:0])
                  CmdHalt: begin
                    run_d   = 1'b0;
                    state_d = StHaltWait;
                  end
                  CmdRun: run_d = 1'b1;
                  CmdStep: begin
                    if (cpu_stopped) begin
                      step_d  = 1'b1;
                      state_d = StStepWait;
                    end else begin
                      err_d = 1'b1;
                    end
                  end
                  CmdRreg: data_d   = reg_rdata;
                  CmdWreg: reg_we_d = 1'b1;
                  CmdRmem, CmdWmem: begin
                    mem_acc_d = 1'b1;
                    mem_we_d  = (dbg_din[2:0] == CmdWmem);
                    cnt_d     = '0;
                    state_d   = StMemWait;
                  end
                  default: err_d = 1'b1;
                endcase
              end
              default: ;  // STATUS is read-only
            endcase
          end
        end
      end
      StHaltWait: if (cpu_stopped) state_d = StAck;
      StStepWait: if (cpu_step_done) state_d = StAck;
      StMemWait: begin
        // mem_ack is checked first so a late ack in the last cycle still counts
        if (mem_ack) begin
          if (!mem_we_q) data_d = mem_rdata;
          mem_acc_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StAck;
        end else if (cnt_q == TimeoutLast) begin
          err_d     = 1'b1;
          mem_acc_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StAck;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAck:     state_d = StWaitLow;
      StWaitLow: if (!dbg_req) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign dbg_ack    = (state_q == StAck);
  assign dbg_dout   = dbg_ack ? (cmd_ack_q ? data_q : rd_q) : '0;
  assign cpu_run    = run_q;
  assign cpu_step   = step_q;
  assign reg_sel    = addr_q[3:0];
  assign reg_wdata  = data_q;
  assign reg_wr_en  = reg_we_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = data_q;
  assign mem_wr_en  = mem_we_q;
  assign mem_access = mem_acc_q;

endmodule

// File: tb/tb_debug_responder.sv
// Bench for debug_responder: directed cases followed by random transfers. A
// transfer-level model tracks ADDR/DATA/err/run plus the CPU register file and
// memory; CPU and memory responders with programmable latencies drive the DUT.
module tb_debug_responder;
  localparam int unsigned MemTimeout = 255;
  localparam int          MemNever   = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dbg_addr = '0;
  logic [31:0] dbg_din = '0;
  logic [31:0] dbg_dout;
  logic        dbg_wr_en = 1'b0;
  logic        dbg_req = 1'b0;
  logic        dbg_ack;
  logic        cpu_run;
  logic        cpu_stopped = 1'b0;
  logic        cpu_step;
  logic        cpu_step_done = 1'b0;
  logic [3:0]  reg_sel;
  logic [31:0] reg_wdata;
  logic        reg_wr_en;
  logic [31:0] reg_rdata = '0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr_en, mem_access;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  debug_responder #(.RUN_ON_RESET(1'b1), .MEM_TIMEOUT(MemTimeout)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_addr(dbg_addr), .dbg_din(dbg_din), .dbg_dout(dbg_dout),
    .dbg_wr_en(dbg_wr_en), .dbg_req(dbg_req), .dbg_ack(dbg_ack), .cpu_run(cpu_run),
    .cpu_stopped(cpu_stopped), .cpu_step(cpu_step), .cpu_step_done(cpu_step_done),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en), .reg_rdata(reg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_access(mem_access), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment state
  int cyc = 0, ack_cnt = 0, step_cnt = 0, wr_cnt = 0, acc_cyc = 0, mem_done = 0;
  int ack_tick = 0, stop_rise = 0;
  int halt_lat = 5, step_lat = 1, mem_lat = 3;
  int halt_cnt = 0, step_wait = 0, mem_wait = 0;
  logic [31:0] regs [16];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic        seen_we = 1'b0;

  // Reference model
  logic [31:0] m_addr = '0, m_data = '0;
  logic        m_err = 1'b0, m_run = 1'b1;
  logic [31:0] m_regs [16];
  logic [31:0] m_mem [logic [31:0]];

  function automatic logic [31:0] mem_fill(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: sample DUT just after the edge, then update the CPU/memory responders.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dbg_ack) begin
      ack_cnt++;
      ack_tick = cyc;
    end
    if (cpu_step) step_cnt++;
    if (mem_access) acc_cyc++;
    if (reg_wr_en) begin
      regs[reg_sel] = reg_wdata;
      wr_cnt++;
    end
    reg_rdata = regs[reg_sel];
    if (cpu_run) begin
      halt_cnt    = 0;
      cpu_stopped = 1'b0;
    end else if (!cpu_stopped) begin
      halt_cnt++;
      if (halt_cnt >= halt_lat) begin
        cpu_stopped = 1'b1;
        stop_rise   = cyc;
      end
    end
    cpu_step_done = 1'b0;
    if (step_wait > 0) begin
      step_wait--;
      if (step_wait == 0) cpu_step_done = 1'b1;
    end
    if (cpu_step) begin
      if (step_lat == 0) cpu_step_done = 1'b1;
      else step_wait = step_lat;
    end
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_access) begin
      if (mem_wait == mem_lat) begin
        mem_ack    = 1'b1;
        seen_addr  = mem_addr;
        seen_we    = mem_wr_en;
        seen_wdata = mem_wdata;
        mem_done++;
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : mem_fill(mem_addr);
      end
      mem_wait++;
    end else begin
      mem_wait = 0;
    end
  endtask

  task automatic xfer(input logic wr, input logic [1:0] a, input logic [31:0] din,
                      input int hold, input int drop_at,
                      output logic [31:0] dout, output int lat, output int acks);
    int a0;
    bit got;
    a0 = ack_cnt;
    got = 1'b0;
    lat = 0;
    dout = '0;
    dbg_req = 1'b1; dbg_wr_en = wr; dbg_addr = a; dbg_din = din;
    for (int i = 1; i <= 2000 && !got; i++) begin
      tick();
      if (i == drop_at) dbg_req = 1'b0;
      if (dbg_ack) begin
        got  = 1'b1;
        lat  = i;
        dout = dbg_dout;
      end
    end
    if (!got) check_eq("ack_seen", 32'(got), 32'd1);
    for (int i = 0; i < hold; i++) tick();
    dbg_req = 1'b0;
    tick();
    tick();
    acks = ack_cnt - a0;
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] a,
                    input logic [31:0] din, input int hold, input int drop_at);
    logic [31:0] exp_dout, dout, maddr;
    logic [2:0]  c;
    logic        stopped0, chk_dout, is_mem, exp_mem;
    int exp_lat, exp_steps, exp_wrs, exp_acc, lat, acks, step0, wr0, acc0, md0;
    stopped0 = cpu_stopped;
    step0 = step_cnt; wr0 = wr_cnt; acc0 = acc_cyc; md0 = mem_done;
    c = din[2:0];
    chk_dout = 1'b1; is_mem = 1'b0; exp_mem = 1'b0;
    exp_lat = 1; exp_steps = 0; exp_wrs = 0; exp_acc = 0; exp_dout = '0;
    maddr = {m_addr[31:2], 2'b00};
    if (!wr) begin
      case (a)
        2'd0: exp_dout = '0;
        2'd1: exp_dout = m_addr;
        2'd2: exp_dout = m_data;
        default: exp_dout = {29'b0, m_err, 1'b0, stopped0};
      endcase
    end else if (a == 2'd1) begin
      m_addr = din; chk_dout = 1'b0;
    end else if (a == 2'd2) begin
      m_data = din; chk_dout = 1'b0;
    end else if (a == 2'd3) begin
      chk_dout = 1'b0;
    end else begin
      m_err = 1'b0;
      case (c)
        3'd0: begin
          m_run = 1'b0;
          exp_lat = (stopped0 ? 1 : halt_lat) + 1;
        end
        3'd1: m_run = 1'b1;
        3'd2: begin
          if (stopped0) begin
            exp_steps = 1;
            exp_lat = step_lat + 2;
          end else begin
            m_err = 1'b1;
          end
        end
        3'd3: m_data = m_regs[m_addr[3:0]];
        3'd4: begin
          m_regs[m_addr[3:0]] = m_data;
          exp_wrs = 1;
        end
        3'd5, 3'd6: begin
          is_mem = 1'b1;
          if (mem_lat < int'(MemTimeout)) begin
            exp_mem = 1'b1;
            exp_lat = mem_lat + 2;
            exp_acc = mem_lat + 1;
            if (c == 3'd6) m_mem[maddr] = m_data;
            else m_data = m_mem.exists(maddr) ? m_mem[maddr] : mem_fill(maddr);
          end else begin
            m_err = 1'b1;
            exp_lat = MemTimeout + 1;
            exp_acc = MemTimeout;
          end
        end
        default: m_err = 1'b1;
      endcase
      exp_dout = m_data;
    end
    xfer(wr, a, din, hold, drop_at, dout, lat, acks);
    check_eq({tag, "_acks"}, 32'(acks), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_dout) check_eq({tag, "_dout"}, dout, exp_dout);
    check_eq({tag, "_run"}, 32'(cpu_run), 32'(m_run));
    check_eq({tag, "_steps"}, 32'(step_cnt - step0), 32'(exp_steps));
    check_eq({tag, "_regwr"}, 32'(wr_cnt - wr0), 32'(exp_wrs));
    if (is_mem) begin
      check_eq({tag, "_acc_cycles"}, 32'(acc_cyc - acc0), 32'(exp_acc));
      check_eq({tag, "_mem_done"}, 32'(mem_done - md0), 32'(exp_mem));
      if (exp_mem) begin
        check_eq({tag, "_mem_addr"}, seen_addr, maddr);
        check_eq({tag, "_mem_we"}, 32'(seen_we), 32'(c == 3'd6));
        if (c == 3'd6) check_eq({tag, "_mem_wdata"}, seen_wdata, m_data);
      end
    end
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a);
    op(tag, 1'b0, a, 32'h0, 0, 0);
  endtask

  task automatic bus_wr(input string tag, input logic [1:0] a, input logic [31:0] d);
    op(tag, 1'b1, a, d, 0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, hold, drop;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      regs[i]   = $urandom;
      m_regs[i] = regs[i];
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check_eq("rst_dbg_dout", dbg_dout, 32'h0);
    check_eq("rst_mem_access", 32'(mem_access), 32'd0);
    check_eq("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check_eq("rst_cpu_step", 32'(cpu_step), 32'd0);
    check_eq("rst_reg_wr_en", 32'(reg_wr_en), 32'd0);
    bus_rd("rst_status", 2'd3);
    bus_rd("rst_addr", 2'd1);
    bus_rd("rst_data", 2'd2);

    // Memory write with a 3-cycle ack
    bus_wr("wm_addr", 2'd1, 32'h0000_1000);
    bus_wr("wm_data", 2'd2, 32'hDEAD_BEEF);
    mem_lat = 3;
    bus_wr("wmem", 2'd0, 32'd6);
    bus_rd("wmem_status", 2'd3);
    bus_wr("rmem_back", 2'd0, 32'd5);

    // Memory read never acknowledged, then ack exactly on the last wait cycle
    mem_lat = MemNever;
    bus_wr("rmem_timeout", 2'd0, 32'd5);
    bus_rd("timeout_status", 2'd3);
    bus_wr("rt_addr", 2'd1, 32'h0000_2003);
    mem_lat = MemTimeout - 1;
    bus_wr("rmem_last_cycle", 2'd0, 32'd5);
    bus_rd("last_cycle_status", 2'd3);

    // Halt with stop after 5 cycles, then single step
    halt_lat = 5;
    bus_wr("halt", 2'd0, 32'd0);
    check_eq("halt_ack_gap", 32'(ack_tick - stop_rise), 32'd1);
    step_lat = 2;
    bus_wr("step", 2'd0, 32'd2);

    // CPU register read and write
    regs[3] = 32'h1234_5678;
    m_regs[3] = 32'h1234_5678;
    bus_wr("rreg_addr", 2'd1, 32'd3);
    bus_wr("rreg", 2'd0, 32'd3);
    bus_wr("wreg_data", 2'd2, 32'hCAFE_F00D);
    bus_wr("wreg", 2'd0, 32'd4);
    check_eq("wreg_file", regs[3], m_regs[3]);
    bus_wr("rreg_back", 2'd0, 32'd3);

    // Step while running, reserved command
    bus_wr("run", 2'd0, 32'd1);
    bus_wr("step_running", 2'd0, 32'd2);
    bus_rd("step_err_status", 2'd3);
    bus_wr("reserved", 2'd0, 32'hFFFF_FFF7);
    bus_rd("reserved_status", 2'd3);
    bus_wr("status_wr", 2'd3, 32'hFFFF_FFFF);
    bus_rd("cmd_rd", 2'd0);

    // Request held long after ack; request dropped mid-command
    op("hold", 1'b0, 2'd2, 32'h0, 10, 0);
    mem_lat = 6;
    op("drop_mid", 1'b1, 2'd0, 32'd6, 0, 2);

    // Reset while waiting on memory
    mem_lat = MemNever;
    dbg_req = 1'b1; dbg_wr_en = 1'b1; dbg_addr = 2'd0; dbg_din = 32'd5;
    repeat (4) tick();
    check_eq("rst_mid_access_before", 32'(mem_access), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_access", 32'(mem_access), 32'd0);
    check_eq("rst_mid_ack", 32'(dbg_ack), 32'd0);
    check_eq("rst_mid_run", 32'(cpu_run), 32'd1);
    dbg_req = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    m_addr = '0; m_data = '0; m_err = 1'b0; m_run = 1'b1;
    step_wait = 0;
    bus_rd("rst_mid_data", 2'd2);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      d = $urandom;
      halt_lat = $urandom_range(1, 6);
      step_lat = $urandom_range(0, 4);
      mem_lat = ($urandom_range(0, 15) == 0) ? MemNever : $urandom_range(0, 8);
      hold = $urandom_range(0, 3);
      drop = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (kind < 2)       op("rnd_rd", 1'b0, 2'($urandom_range(0, 3)), d, hold, drop);
      else if (kind == 2) op("rnd_addr", 1'b1, 2'd1, d, hold, drop);
      else if (kind == 3) op("rnd_data", 1'b1, 2'd2, d, hold, drop);
      else if (kind == 4) op("rnd_status", 1'b1, 2'd3, d, hold, drop);
      else                op("rnd_cmd", 1'b1, 2'd0, d, hold, drop);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
